// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared types and defaults for the shift command sequencer and its FIFO.
// Optional result counter is enabled with `define SHIFT_SEQ_CNT_EN (see top).
package shift_pkg;

   localparam int SHIFT_DATA_W = 32;
   localparam int SHIFT_AMT_W  = 5;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [SHIFT_DATA_W-1:0] data;
      logic [SHIFT_AMT_W-1:0]  amt;
      logic                    dir;
   } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_sequencer_if.sv
// Command, shifter and result signals of the shift command sequencer.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// valid never waits on ready, and payload is held stable while valid & !ready.
interface shift_cmd_sequencer_if #(
   parameter int DATA_W = shift_pkg::SHIFT_DATA_W,
   parameter int AMT_W  = shift_pkg::SHIFT_AMT_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_data;
   logic [AMT_W-1:0]  cmd_amt;
   logic              cmd_dir;

   logic [DATA_W-1:0] sh_data_in;
   logic [AMT_W-1:0]  sh_shift_amt;
   logic              sh_dir;
   logic [DATA_W-1:0] sh_data_out;

   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [AMT_W-1:0]  res_amt;
   logic              res_dir;

   modport slave (
      input  cmd_valid, cmd_data, cmd_amt, cmd_dir, res_ready, sh_data_out,
      output cmd_ready, res_valid, res_data, res_amt, res_dir,
             sh_data_in, sh_shift_amt, sh_dir
   );

   modport master (
      output cmd_valid, cmd_data, cmd_amt, cmd_dir, res_ready, sh_data_out,
      input  cmd_ready, res_valid, res_data, res_amt, res_dir,
             sh_data_in, sh_shift_amt, sh_dir
   );
endinterface

// File: rtl/shift_cmd_sequencer_fifo.sv
// DEPTH-entry command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module shift_cmd_fifo
   import shift_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_en,
   input  shift_cmd_t             wr_cmd,
   input  logic                   rd_en,
   output shift_cmd_t             rd_cmd,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   shift_cmd_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign rd_cmd = mem[rd_ptr];
   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);

   // Storage needs no reset: an entry is only read once count covers it.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_cmd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/shift_cmd_sequencer.sv
// Issues queued shift commands to a combinational barrel shifter and registers the result.
// `define SHIFT_SEQ_CNT_EN adds res_count, a wrapping count of result handshakes.
module shift_cmd_sequencer
   import shift_pkg::*;
#(
   parameter int DATA_W = SHIFT_DATA_W,
   parameter int AMT_W  = SHIFT_AMT_W,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   shift_cmd_sequencer_if.slave   bus,
   output logic [1:0]             dbg_state,
   output logic [$clog2(DEPTH):0] dbg_count
`ifdef SHIFT_SEQ_CNT_EN
  ,output logic [15:0]            res_count
`endif
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_STALL = STALL;

   shift_cmd_t        wr_cmd;
   shift_cmd_t        head;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              issue;
   logic              pop;
   logic              res_hs;
   logic              rv_next;
   logic              cnt_next_zero;
   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic              res_valid_q;
   logic [DATA_W-1:0] res_data_q;
   logic [AMT_W-1:0]  res_amt_q;
   logic              res_dir_q;

   assign wr_cmd = '{data: bus.cmd_data, amt: bus.cmd_amt, dir: bus.cmd_dir};

   // flush wins over both push and issue in its cycle.
   assign push   = bus.cmd_valid & !full & !flush;
   assign issue  = !empty & (!res_valid_q | bus.res_ready);
   assign pop    = issue & !flush;
   assign res_hs = res_valid_q & bus.res_ready;

   shift_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .wr_en  (push),
      .wr_cmd (wr_cmd),
      .rd_en  (pop),
      .rd_cmd (head),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   assign bus.cmd_ready    = !full;
   assign bus.sh_data_in   = empty ? '0 : head.data;
   assign bus.sh_shift_amt = empty ? '0 : head.amt;
   assign bus.sh_dir       = empty ? 1'b0 : head.dir;

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_amt   = res_amt_q;
   assign bus.res_dir   = res_dir_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_amt_q   <= '0;
         res_dir_q   <= 1'b0;
      end else if (flush) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_amt_q   <= '0;
         res_dir_q   <= 1'b0;
      end else if (issue) begin
         res_valid_q <= 1'b1;
         res_data_q  <= bus.sh_data_out;
         res_amt_q   <= head.amt;
         res_dir_q   <= head.dir;
      end else if (res_hs) begin
         res_valid_q <= 1'b0;
      end
   end

   // State is an observation of FIFO occupancy and slot status; it does not gate datapath.
   assign rv_next       = issue | (res_valid_q & !bus.res_ready);
   assign cnt_next_zero = ((count == '0) & !push) |
                          ((count == CNT_W'(1)) & pop & !push);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (push) state_d = ST_RUN;
         ST_RUN: begin
            if (res_valid_q & !bus.res_ready)  state_d = ST_STALL;
            else if (cnt_next_zero & !rv_next) state_d = ST_IDLE;
         end
         ST_STALL: if (bus.res_ready) state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase
      if (flush) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   assign dbg_state = state_q;
   assign dbg_count = count;

`ifdef SHIFT_SEQ_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         res_count <= '0;
      else if (flush)  res_count <= '0;
      else if (res_hs) res_count <= res_count + 16'd1;
   end
`endif
endmodule
